// File: rtl/dma_bus_arbiter.sv
// OAM-style DMA engine sharing one memory port with the CPU.
// A write to the DMA register starts a DELAY then a 4-phase-per-byte copy into OAM.
module dma_bus_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] HRAM_LO      = 16'hFF80,
  parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_rd_addr,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [7:0]  o_cpu_rd_data,
  output logic [15:0] o_mem_rd_addr,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data,
  output logic        o_dma_active
);

  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  dma_reg;
  logic [7:0]  byte_buf_reg;
  logic [7:0]  held_data_reg;
  logic        pend_valid_reg;
  logic [15:0] pend_addr_reg;
  logic [7:0]  pend_data_reg;
  logic        rd_owner_dma_reg;
  logic        rd_active_reg;
  logic [15:0] rd_addr_reg;

  logic trigger, dma_active, dma_rd_slot, oam_slot;
  logic wr_in_hram, rd_in_hram, cpu_wr_ok, pend_capture, pend_issue;

  assign trigger      = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);
  assign dma_active   = (state_reg != IDLE);
  assign dma_rd_slot  = (state_reg == XFER) && (phase_reg == 2'd0);
  assign oam_slot     = (state_reg == XFER) && (phase_reg == 2'd2);
  assign wr_in_hram   = (i_cpu_wr_addr >= HRAM_LO) && (i_cpu_wr_addr <= HRAM_HI);
  assign rd_in_hram   = (rd_addr_reg >= HRAM_LO) && (rd_addr_reg <= HRAM_HI);
  assign cpu_wr_ok    = i_cpu_wr_en && !trigger && (!dma_active || wr_in_hram);
  // A CPU write colliding with the OAM slot, or queued behind a held write, waits a cycle.
  assign pend_capture = cpu_wr_ok && (oam_slot || pend_valid_reg);
  assign pend_issue   = pend_valid_reg && !oam_slot;
  assign o_dma_active = dma_active;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg        <= IDLE;
      phase_reg        <= 2'd0;
      idx_reg          <= 8'd0;
      dma_reg          <= 8'hFF;
      byte_buf_reg     <= 8'h00;
      held_data_reg    <= 8'hFF;
      pend_valid_reg   <= 1'b0;
      pend_addr_reg    <= 16'h0000;
      pend_data_reg    <= 8'h00;
      rd_owner_dma_reg <= 1'b0;
      rd_active_reg    <= 1'b0;
      rd_addr_reg      <= 16'h0000;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      idx_reg          <= idx_next;
      rd_owner_dma_reg <= dma_rd_slot;
      rd_active_reg    <= dma_active;
      rd_addr_reg      <= i_cpu_rd_addr;
      if (trigger)
        dma_reg <= i_cpu_wr_data;
      if ((state_reg == XFER) && (phase_reg == 2'd1))
        byte_buf_reg <= i_mem_rd_data;
      if (!rd_owner_dma_reg)
        held_data_reg <= i_mem_rd_data;
      if (pend_capture) begin
        pend_valid_reg <= 1'b1;
        pend_addr_reg  <= i_cpu_wr_addr;
        pend_data_reg  <= i_cpu_wr_data;
      end else if (pend_issue) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    case (state_reg)
      DELAY: begin
        phase_next = phase_reg + 2'd1;
        if (phase_reg == 2'd3)
          state_next = XFER;
      end
      XFER: begin
        phase_next = phase_reg + 2'd1;
        if (phase_reg == 2'd3) begin
          if (idx_reg == LAST_IDX)
            state_next = IDLE;
          else
            idx_next = idx_reg + 8'd1;
        end
      end
      default: ;
    endcase
    if (trigger) begin
      state_next = DELAY;
      phase_next = 2'd0;
      idx_next   = 8'd0;
    end
  end

  always_comb begin
    o_mem_rd_addr = 16'h0000;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_addr = 16'h0000;
    o_mem_wr_data = 8'h00;
    o_cpu_rd_data = 8'hFF;
    if (!i_rst) begin
      o_mem_rd_addr = dma_rd_slot ? {dma_reg, idx_reg} : i_cpu_rd_addr;
      if (oam_slot && !trigger) begin
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = OAM_BASE + {8'h00, idx_reg};
        o_mem_wr_data = byte_buf_reg;
      end else if (pend_issue) begin
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = pend_addr_reg;
        o_mem_wr_data = pend_data_reg;
      end else if (cpu_wr_ok && !pend_capture) begin
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = i_cpu_wr_addr;
        o_mem_wr_data = i_cpu_wr_data;
      end
      // Read data follows the owner/address seen on the previous clock.
      if (rd_addr_reg == DMA_REG_ADDR)
        o_cpu_rd_data = dma_reg;
      else if (rd_owner_dma_reg)
        o_cpu_rd_data = held_data_reg;
      else if (rd_active_reg && !rd_in_hram)
        o_cpu_rd_data = 8'hFF;
      else
        o_cpu_rd_data = i_mem_rd_data;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: memory model plus write scoreboard.
// Expected memory writes are queued as stimulus is driven and popped as the DUT issues them.
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_rd_addr;
  logic        cpu_wr_en;
  logic [15:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        dma_active;

  int n_checks = 0;
  int n_fail   = 0;
  int act_cnt;
  logic [23:0] exp_q[$];
  bit [7:0] mem [65536];

  always #5 clk = ~clk;

  dma_bus_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cpu_rd_addr (cpu_rd_addr),
    .i_cpu_wr_en   (cpu_wr_en),
    .i_cpu_wr_addr (cpu_wr_addr),
    .i_cpu_wr_data (cpu_wr_data),
    .o_cpu_rd_data (cpu_rd_data),
    .o_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_wr_addr (mem_wr_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_dma_active  (dma_active)
  );

  // Synchronous memory: one-clock read latency; contents (re)loaded while in reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 160; i++) begin
        mem[16'(32'hC000 + i)] <= 8'(i) ^ 8'h5A;
        mem[16'(32'hD000 + i)] <= 8'(i) ^ 8'hA3;
        mem[16'(32'hE000 + i)] <= 8'(i + 1);
      end
      mem[16'h8000] <= 8'h12;
      mem[16'hFF80] <= 8'h3C;
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_rd_addr];
  end

  function automatic void chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  function automatic logic [7:0] src_byte(input logic [7:0] src, input int b);
    case (src)
      8'hC0:   return 8'(b) ^ 8'h5A;
      8'hD0:   return 8'(b) ^ 8'hA3;
      default: return 8'(b + 1);
    endcase
  endfunction

  // Cycle n after a trigger: byte (n-5)/4 hits its OAM write slot when (n-5)%4 == 2.
  task automatic xfer_push(input int n, input logic [7:0] src);
    int b;
    b = (n - 5) / 4;
    if (n >= 5 && ((n - 5) % 4) == 2 && b < 160)
      exp_q.push_back({16'(32'hFE00 + b), src_byte(src, b)});
  endtask

  always @(negedge clk) begin
    if (!rst && mem_wr_en) begin
      logic [23:0] e;
      $display("mem write %h <= %h", mem_wr_addr, mem_wr_data);
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed %h/%h expected no write", mem_wr_addr, mem_wr_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_write", {mem_wr_addr, mem_wr_data}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input logic [7:0] src);
    cpu_wr_en   = 1'b1;
    cpu_wr_addr = 16'hFF46;
    cpu_wr_data = src;
  endtask

  initial begin
    cpu_rd_addr = 16'h1234;
    cpu_wr_en   = 1'b1;
    cpu_wr_addr = 16'hC123;
    cpu_wr_data = 8'h55;
    #7;
    chk("rst_wr_en",    24'(mem_wr_en),   24'h0);
    chk("rst_active",   24'(dma_active),  24'h0);
    chk("rst_rd_addr",  24'(mem_rd_addr), 24'h0);
    chk("rst_wr_addr",  24'(mem_wr_addr), 24'h0);
    chk("rst_wr_data",  24'(mem_wr_data), 24'h0);
    chk("rst_cpu_rd",   24'(cpu_rd_data), 24'hFF);
    cpu_wr_en   = 1'b0;
    cpu_rd_addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle pass-through
    cpu_rd_addr = 16'hFF46;
    cpu_wr_en   = 1'b1;
    cpu_wr_addr = 16'hC123;
    cpu_wr_data = 8'h77;
    exp_q.push_back({16'hC123, 8'h77});
    #3;
    chk("idle_rd_addr", 24'(mem_rd_addr), 24'hFF46);
    chk("idle_active",  24'(dma_active),  24'h0);
    tick();
    cpu_wr_en = 1'b0;
    #3;
    chk("idle_rd_ff46", 24'(cpu_rd_data), 24'hFF);
    $display("idle read FF46 -> %h", cpu_rd_data);

    // Transfer 1 from C000 with CPU traffic interleaved
    tick();
    cpu_rd_addr = 16'h0000;
    trig(8'hC0);
    #3;
    chk("trig_not_fwd", 24'(mem_wr_en), 24'h0);
    act_cnt = 0;
    for (int n = 1; n <= 650; n++) begin
      tick();
      xfer_push(n, 8'hC0);
      case (n)
        1:   cpu_wr_en = 1'b0;
        46:  cpu_rd_addr = 16'h8000;
        47: begin
          cpu_rd_addr = 16'hFF80;
          cpu_wr_en   = 1'b1;
          cpu_wr_addr = 16'hFF90;
          cpu_wr_data = 8'hA5;
          exp_q.push_back({16'hFF90, 8'hA5});
        end
        48:  cpu_wr_en = 1'b0;
        49:  cpu_rd_addr = 16'hFF90;
        50:  cpu_rd_addr = 16'h0000;
        85: begin
          cpu_wr_en   = 1'b1;
          cpu_wr_addr = 16'h9000;
          cpu_wr_data = 8'h11;
        end
        86:  cpu_wr_en = 1'b0;
        126: cpu_rd_addr = 16'hFF46;
        127: cpu_rd_addr = 16'h0000;
        default: ;
      endcase
      #3;
      if (dma_active) act_cnt++;
      case (n)
        5:   chk("first_src_addr",  24'(mem_rd_addr), 24'hC000);
        47:  chk("rd_8000_blocked", 24'(cpu_rd_data), 24'hFF);
        48:  chk("rd_ff80_hram",    24'(cpu_rd_data), 24'h3C);
        49: begin
          chk("rd_ff80_ph3",    24'(cpu_rd_data), 24'h3C);
          chk("dma_owns_ph0",   24'(mem_rd_addr), 24'hC00B);
        end
        50:  chk("rd_ph0_held",     24'(cpu_rd_data), 24'h3C);
        85:  chk("drop_non_hram",   24'(mem_wr_en),   24'h0);
        127: chk("rd_dma_reg",      24'(cpu_rd_data), 24'hC0);
        644: chk("active_last",     24'(dma_active),  24'h1);
        645: chk("active_cleared",  24'(dma_active),  24'h0);
        default: ;
      endcase
    end
    chk("xfer1_active_cycles", 24'(act_cnt), 24'd644);
    chk("xfer1_all_writes",    24'(exp_q.size()), 24'd0);
    $display("transfer C0 done, active cycles %0d", act_cnt);

    // Transfer 2: C0 aborted at byte 50 by a D0 trigger
    tick();
    trig(8'hC0);
    #3;
    for (int n = 1; n <= 205; n++) begin
      tick();
      xfer_push(n, 8'hC0);
      if (n == 1) cpu_wr_en = 1'b0;
      if (n == 205) trig(8'hD0);
      #3;
      if (n == 205) chk("retrig_no_write", 24'(mem_wr_en), 24'h0);
    end
    act_cnt = 0;
    for (int m = 1; m <= 650; m++) begin
      tick();
      xfer_push(m, 8'hD0);
      if (m == 1) cpu_wr_en = 1'b0;
      #3;
      if (dma_active) act_cnt++;
      if (m == 4) begin
        chk("retrig_delay_rd", 24'(mem_rd_addr), 24'h0000);
        chk("retrig_delay_act", 24'(dma_active), 24'h1);
      end
      if (m == 5) chk("retrig_src_d000", 24'(mem_rd_addr), 24'hD000);
    end
    chk("xfer2_active_cycles", 24'(act_cnt), 24'd644);
    chk("xfer2_all_writes",    24'(exp_q.size()), 24'd0);
    $display("transfer D0 after abort done, active cycles %0d", act_cnt);

    // Transfer 3 from E000, reset hits byte 80 phase 2
    tick();
    trig(8'hE0);
    #3;
    for (int n = 1; n <= 326; n++) begin
      tick();
      xfer_push(n, 8'hE0);
      if (n == 1) cpu_wr_en = 1'b0;
      #3;
      if (n == 5) chk("src_e000_verbatim", 24'(mem_rd_addr), 24'hE000);
    end
    tick();
    #1;
    chk("b80_oam_pending", {7'h0, mem_wr_en, mem_wr_addr}, {7'h0, 1'b1, 16'hFE50});
    chk("b80_oam_data",    24'(mem_wr_data), 24'(src_byte(8'hE0, 80)));
    rst = 1'b1;
    #1;
    chk("midrst_wr_en",   24'(mem_wr_en),   24'h0);
    chk("midrst_active",  24'(dma_active),  24'h0);
    chk("midrst_wr_addr", 24'(mem_wr_addr), 24'h0);
    chk("midrst_cpu_rd",  24'(cpu_rd_data), 24'hFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("xfer3_all_writes", 24'(exp_q.size()), 24'd0);
    cpu_rd_addr = 16'hFF46;
    #3;
    chk("post_rst_idle", 24'(dma_active), 24'h0);
    tick();
    #3;
    chk("post_rst_ff46", 24'(cpu_rd_data), 24'hFF);
    $display("post-reset read FF46 -> %h", cpu_rd_data);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, meaning the DMA trigger/source register address.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, meaning the destination base address.
REQ-003 SHALL have parameter DMA_LEN, default 160, meaning the number of bytes per transfer.
REQ-004 SHALL have parameters HRAM_LO = 16'hFF80 and HRAM_HI = 16'hFFFE, meaning the window the CPU may still reach during DMA.
REQ-005 i_clk  in  1  sole clock; every register updates on its rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_cpu_rd_addr  in  16  CPU read address.
REQ-008 i_cpu_wr_en / i_cpu_wr_addr / i_cpu_wr_data  in  1/16/8  CPU write request, address and data.
REQ-009 o_cpu_rd_data  out  8  read data returned to the CPU.
REQ-010 o_mem_rd_addr  out  16  memory read address; memory returns data one clock later on i_mem_rd_data.
REQ-011 i_mem_rd_data  in  8  memory read data.
REQ-012 o_mem_wr_en / o_mem_wr_addr / o_mem_wr_data  out  1/16/8  memory write port.
REQ-013 o_dma_active  out  1  high while the block is in DELAY or XFER.

Function
REQ-014 SHALL implement states IDLE, DELAY and XFER, plus a 2-bit phase counter, an 8-bit byte index idx and an 8-bit dma_reg.
REQ-015 Trigger: a rising edge with i_cpu_wr_en=1 and i_cpu_wr_addr==DMA_REG_ADDR SHALL load dma_reg, clear idx and phase, and enter DELAY; this applies from any state.
REQ-016 A trigger SHALL NOT be forwarded to the memory write port.
REQ-017 DELAY SHALL last exactly 4 clocks, then enter XFER with phase=0.
REQ-018 XFER phase 0 SHALL drive o_mem_rd_addr = {dma_reg, idx}.
REQ-019 XFER phase 1 SHALL latch i_mem_rd_data into a byte buffer.
REQ-020 XFER phase 2 SHALL drive o_mem_wr_en=1, o_mem_wr_addr = OAM_BASE + idx and o_mem_wr_data = buffer.
REQ-021 XFER phase 3 SHALL increment idx; if idx == DMA_LEN-1, it SHALL instead return to IDLE.
REQ-022 A full transfer SHALL take 4 + 4*DMA_LEN = 644 clocks from trigger to IDLE.
REQ-023 The source address SHALL be {dma_reg, idx} verbatim, with no remapping for dma_reg >= 8'hE0.
REQ-024 In IDLE, the CPU read/write buses SHALL pass straight to the memory ports.
REQ-025 When dma_active is high, CPU writes outside HRAM_LO..HRAM_HI, other than the trigger, SHALL be dropped.
REQ-026 When dma_active is high, CPU reads outside the HRAM window SHALL return 8'hFF.
REQ-027 During DMA, CPU HRAM reads SHALL own o_mem_rd_addr in every cycle except XFER phase 0.
REQ-028 o_cpu_rd_data SHALL be selected using the owner and address registered on the previous clock; when that owner was the DMA, it SHALL return the last CPU-owned read data (held register).
REQ-029 A CPU read of DMA_REG_ADDR SHALL return dma_reg one clock after the address is presented, in all states.
REQ-030 During DMA, a CPU HRAM write landing on XFER phase 2 SHALL be held one clock and issued in phase 3 with unchanged address and data; in all other phases it SHALL be forwarded in the same clock.
REQ-031 A re-trigger during DELAY or XFER SHALL abort the current transfer without a further OAM write and restart per REQ-015.

Reset
REQ-032 i_rst SHALL immediately set state=IDLE, idx=0, phase=0, dma_reg=8'hFF, held read data=8'hFF, and clear any pending CPU write.
REQ-033 During reset: o_mem_wr_en=0, o_dma_active=0, o_mem_rd_addr=16'h0000, o_mem_wr_addr=16'h0000, o_mem_wr_data=8'h00, o_cpu_rd_data=8'hFF.
REQ-034 Reset asserted mid-transfer SHALL suppress any further OAM write, including one in phase 2 of the current byte.

Verification
REQ-035 Reset release, then read 16'hFF46 -> returns 8'hFF; o_dma_active=0; a CPU write to 16'hC123 appears on the memory write port in the same clock.
REQ-036 Write 8'hC0 to 16'hFF46 with memory[C000+i]=i^8'h5A -> o_dma_active high for 644 clocks; 160 writes appear at FE00..FE9F with data i^8'h5A; the first read address C000 appears on clock 5 after the trigger.
REQ-037 During XFER, read 16'h8000 -> 8'hFF; read 16'hFF80 with memory=8'h3C -> 8'h3C; read issued in phase 0 -> returns the held previous value.
REQ-038 During XFER, write 8'hA5 to 16'hFF90 in phase 2 -> memory write of FF90/A5 in phase 3, and the OAM write in phase 2 is intact.
REQ-039 Write 8'hD0 to 16'hFF46 after byte 50 -> idx restarts at 0, a 4-clock DELAY follows, and the source is D000..D09F; no write to FE32 from the old transfer occurs.
REQ-040 Assert i_rst at byte 80, phase 2 -> o_mem_wr_en=0 with no clock edge; after release, state IDLE and FF46 reads 8'hFF.
